// File: rtl/led_bcm_scheduler.sv
// BCM scheduler for a HUB75 panel: row shift requests, latch/row strobes, plane-weighted OE.
// Optional OE_GLOBAL_DIM_EN adds a brightness input that scales every OE window.
//
// state    | meaning
// IDLE     | stopped; waits for enable
// PASS_RST | one-cycle AL422 read-pointer rewind before row 0 of a plane
// SHIFT    | shifter busy with the next row; waits for shift_done
// WAIT_OE  | row shifted, current OE window still running
// BLANK    | OE low for DEAD_CYCLES clocks ahead of the latch
// LATCH    | latch pulse; next cycle starts OE and advances row/plane
module led_bcm_scheduler #(
    parameter int ROWS        = 8,
    parameter int PLANES      = 4,
    parameter int OE_UNIT     = 4,
    parameter int DEAD_CYCLES = 2
) (
    input  logic       in_clk,
    input  logic       in_nrst,
`ifdef OE_GLOBAL_DIM_EN
    input  logic [7:0] brightness,
`endif
    input  logic       enable,
    input  logic       shift_done,
    output logic       shift_start,
    output logic [4:0] shift_row,
    output logic [2:0] shift_plane,
    output logic [4:0] led_row,
    output logic       led_lat,
    output logic       led_oe,
    output logic       al422_nrst,
    output logic       frame_done,
    output logic       busy
);

    localparam int CW = $clog2(OE_UNIT << (PLANES - 1)) + 1;
    localparam int DW = (DEAD_CYCLES > 2) ? $clog2(DEAD_CYCLES) : 1;
    localparam logic [4:0] LAST_ROW   = 5'(ROWS - 1);
    localparam logic [2:0] LAST_PLANE = 3'(PLANES - 1);

    typedef enum logic [2:0] {
        IDLE, PASS_RST, SHIFT, WAIT_OE, BLANK, LATCH
    } state_t;

    state_t          state;
    logic [CW-1:0]   oe_cnt;
    logic [DW-1:0]   dead_cnt;
    logic [15:0]     oe_base;
    logic [CW-1:0]   oe_load;

    assign oe_base = 16'(OE_UNIT) << shift_plane;

`ifdef OE_GLOBAL_DIM_EN
    logic [15:0] oe_prod;
    logic [15:0] oe_scaled;

    // (base * (brightness+1)) >> 8, never shorter than one clock
    always_comb begin
        oe_prod   = oe_base * {8'd0, brightness} + oe_base;
        oe_scaled = oe_prod >> 8;
        oe_load   = (oe_scaled == 16'd0) ? CW'(1) : CW'(oe_scaled);
    end
`else
    assign oe_load = CW'(oe_base);
`endif

    always_ff @(posedge in_clk or negedge in_nrst) begin
        if (!in_nrst) begin
            state       <= IDLE;
            oe_cnt      <= '0;
            dead_cnt    <= '0;
            shift_start <= 1'b0;
            shift_row   <= 5'd0;
            shift_plane <= 3'd0;
            led_row     <= LAST_ROW;
            led_lat     <= 1'b0;
            led_oe      <= 1'b0;
            al422_nrst  <= 1'b1;
            frame_done  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            shift_start <= 1'b0;
            led_lat     <= 1'b0;
            al422_nrst  <= 1'b1;
            frame_done  <= 1'b0;

            if (oe_cnt != '0) begin
                oe_cnt <= oe_cnt - 1'b1;
                led_oe <= (oe_cnt != CW'(1));
            end

            case (state)
                IDLE: begin
                    // a final OE window may still be draining after a stop
                    busy <= enable || (oe_cnt > CW'(1));
                    if (enable) begin
                        state      <= PASS_RST;
                        al422_nrst <= 1'b0;
                    end
                end
                PASS_RST: begin
                    state       <= SHIFT;
                    shift_start <= 1'b1;
                end
                SHIFT: begin
                    if (shift_done) begin
                        if (!led_oe && oe_cnt == '0) begin
                            state    <= BLANK;
                            dead_cnt <= DW'(DEAD_CYCLES - 1);
                        end else begin
                            state <= WAIT_OE;
                        end
                    end
                end
                WAIT_OE: begin
                    if (!led_oe && oe_cnt == '0) begin
                        state    <= BLANK;
                        dead_cnt <= DW'(DEAD_CYCLES - 1);
                    end
                end
                BLANK: begin
                    if (dead_cnt == '0) begin
                        state   <= LATCH;
                        led_lat <= 1'b1;
                        led_row <= shift_row;
                    end else begin
                        dead_cnt <= dead_cnt - 1'b1;
                    end
                end
                LATCH: begin
                    oe_cnt <= oe_load;
                    led_oe <= 1'b1;
                    if (shift_row == LAST_ROW) begin
                        shift_row <= 5'd0;
                        if (shift_plane == LAST_PLANE) begin
                            shift_plane <= 3'd0;
                            frame_done  <= 1'b1;
                            if (enable) begin
                                state      <= PASS_RST;
                                al422_nrst <= 1'b0;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            shift_plane <= shift_plane + 3'd1;
                            state       <= PASS_RST;
                            al422_nrst  <= 1'b0;
                        end
                    end else begin
                        shift_row   <= shift_row + 5'd1;
                        state       <= SHIFT;
                        shift_start <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
